// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encoding, instruction width and the special instruction words.
package inst_fetch_unit_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [INST_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: program load port, core control and instruction output.
// The master side is the fetch unit itself.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    import inst_fetch_unit_pkg::*;

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [INST_W-1:0] load_data;
    logic              start;
    logic              stall;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic [INST_W-1:0] Inst;
    logic              inst_valid;
    logic [ADDR_W-1:0] inst_pc;
    logic              halted;

    modport master (
        input  load_en, load_addr, load_data, start,
        input  stall, redirect_en, redirect_pc,
        output Inst, inst_valid, inst_pc, halted
    );

    modport slave (
        output load_en, load_addr, load_data, start,
        output stall, redirect_en, redirect_pc,
        input  Inst, inst_valid, inst_pc, halted
    );

endinterface

// File: rtl/inst_fetch_unit_store.sv
// Word-addressed program store: synchronous write, combinational read.
// Contents are deliberately not reset so a program survives rst_n.
module inst_store
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [INST_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/HALT control, PC walk over the program
// store, stall hold, one-bubble redirect and halt on a sentinel word.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int unsigned       RESET_PC  = 0,
    parameter logic [INST_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    inst_fetch_unit_if.master    bus
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              we;
    logic [INST_W-1:0] rdata;

    inst_store #(
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST;
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        we      = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                we      = bus.load_en;
                inst_d  = NOP_WORD;
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = PC_RST;
                end
            end
            S_RUN: begin
                // Redirect wins over stall: the bubble is inserted regardless.
                if (bus.redirect_en) begin
                    pc_d    = bus.redirect_pc;
                    inst_d  = NOP_WORD;
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (rdata == HALT_WORD) begin
                    state_d = S_HALT;
                    inst_d  = NOP_WORD;
                    valid_d = 1'b0;
                end else begin
                    inst_d  = rdata;
                    valid_d = 1'b1;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.Inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst_pc    = ipc_q;
    assign bus.halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed-vector bench for inst_fetch_unit: an 8-bit-PC instance for the
// program scenarios and a 2-bit-PC instance for PC wrap-around.
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    inst_fetch_unit_if #(.ADDR_W(8)) ia ();
    inst_fetch_unit_if #(.ADDR_W(2)) ib ();

    inst_fetch_unit #(.ADDR_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    inst_fetch_unit #(.ADDR_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    // {inst_valid, halted, inst_pc, Inst}
    logic [41:0] got_a;
    logic [35:0] got_b;
    assign got_a = {ia.inst_valid, ia.halted, ia.inst_pc, ia.Inst};
    assign got_b = {ib.inst_valid, ib.halted, ib.inst_pc, ib.Inst};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.load_en = 0; ia.load_addr = '0; ia.load_data = '0;
        ia.start = 0; ia.stall = 0; ia.redirect_en = 0; ia.redirect_pc = '0;
        ib.load_en = 0; ib.load_addr = '0; ib.load_data = '0;
        ib.start = 0; ib.stall = 0; ib.redirect_en = 0; ib.redirect_pc = '0;
    endtask

    task automatic start_a();
        ia.start = 1;
        tick();
        ia.start = 0;
    endtask

    task automatic test_reset();
        logic [41:0] exp;
        exp = {2'b00, 8'd0, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL reset_init got=%h exp=%h", got_a, exp);
        end
        #3 rst_n = 1;
        tick();
    endtask

    task automatic test_load();
        logic [31:0] prog [4];
        prog[0] = 32'h0000_0820;
        prog[1] = 32'h4001_0001;
        prog[2] = 32'h0021_0820;
        prog[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            ia.load_en = 1;
            ia.load_addr = 8'(i);
            ia.load_data = prog[i];
            tick();
        end
        ia.load_en = 0;
    endtask

    task automatic test_basic();
        logic [41:0] exp;
        start_a();
        exp = {2'b00, 8'd0, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL basic_latency got=%h exp=%h", got_a, exp);
        end
        tick();
        exp = {2'b10, 8'd0, 32'h0000_0820};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL basic_pc0 got=%h exp=%h", got_a, exp);
        end
        tick();
        exp = {2'b10, 8'd1, 32'h4001_0001};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL basic_pc1 got=%h exp=%h", got_a, exp);
        end
        tick();
        exp = {2'b10, 8'd2, 32'h0021_0820};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL basic_pc2 got=%h exp=%h", got_a, exp);
        end
        tick();
        exp = {2'b01, 8'd2, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL basic_halt got=%h exp=%h", got_a, exp);
        end
    endtask

    task automatic test_stall();
        logic [41:0] exp;
        start_a();
        tick();
        tick();
        ia.stall = 1;
        exp = {2'b10, 8'd1, 32'h4001_0001};
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (got_a !== exp) begin
                nerr++;
                $display("FAIL stall_hold%0d got=%h exp=%h", i, got_a, exp);
            end
        end
        ia.stall = 0;
        tick();
        exp = {2'b10, 8'd2, 32'h0021_0820};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL stall_resume got=%h exp=%h", got_a, exp);
        end
        tick();
    endtask

    task automatic test_redirect();
        logic [41:0] exp;
        start_a();
        tick();
        tick();
        ia.stall = 1;
        ia.redirect_en = 1;
        ia.redirect_pc = 8'd0;
        tick();
        ia.stall = 0;
        ia.redirect_en = 0;
        exp = {2'b00, 8'd1, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL redirect_bubble got=%h exp=%h", got_a, exp);
        end
        tick();
        exp = {2'b10, 8'd0, 32'h0000_0820};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL redirect_target got=%h exp=%h", got_a, exp);
        end
        tick();
        tick();
        tick();
        exp = {2'b01, 8'd2, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL redirect_halt got=%h exp=%h", got_a, exp);
        end
    endtask

    task automatic test_load_in_run();
        logic [41:0] exp;
        start_a();
        ia.load_en = 1;
        ia.load_addr = 8'd1;
        ia.load_data = 32'h0;
        tick();
        tick();
        exp = {2'b10, 8'd1, 32'h4001_0001};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL runload_now got=%h exp=%h", got_a, exp);
        end
        ia.load_en = 0;
        tick();
        tick();
        start_a();
        tick();
        tick();
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL runload_rerun got=%h exp=%h", got_a, exp);
        end
        tick();
        tick();
    endtask

    task automatic test_load_start_same();
        logic [41:0] exp;
        ia.load_en = 1;
        ia.load_addr = 8'd0;
        ia.load_data = 32'hAAAA_0001;
        ia.start = 1;
        tick();
        ia.load_en = 0;
        ia.start = 0;
        tick();
        exp = {2'b10, 8'd0, 32'hAAAA_0001};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL loadstart got=%h exp=%h", got_a, exp);
        end
        tick();
        tick();
        tick();
        exp = {2'b01, 8'd2, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL loadstart_halt got=%h exp=%h", got_a, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [41:0] exp;
        start_a();
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        exp = {2'b00, 8'd0, 32'h0};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL reset_async got=%h exp=%h", got_a, exp);
        end
        #1 rst_n = 1;
        start_a();
        tick();
        exp = {2'b10, 8'd0, 32'hAAAA_0001};
        nvec++;
        if (got_a !== exp) begin
            nerr++;
            $display("FAIL reset_retain got=%h exp=%h", got_a, exp);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] w [4];
        logic [35:0] exp;
        w[0] = 32'h1111_0000;
        w[1] = 32'h2222_0001;
        w[2] = 32'h3333_0002;
        w[3] = 32'h4444_0003;
        for (int i = 0; i < 4; i++) begin
            ib.load_en = 1;
            ib.load_addr = 2'(i);
            ib.load_data = w[i];
            tick();
        end
        ib.load_en = 0;
        ib.start = 1;
        tick();
        ib.start = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = {2'b10, 2'(i % 4), w[i % 4]};
            nvec++;
            if (got_b !== exp) begin
                nerr++;
                $display("FAIL wrap%0d got=%h exp=%h", i, got_b, exp);
            end
        end
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_load();
        test_basic();
        test_stall();
        test_redirect();
        test_load_in_run();
        test_load_start_same();
        test_reset_mid_run();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
